// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// FSM states and the default bus timeout.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_ld_fmt.sv
// Load formatter: picks the byte/half lane out of the read word and
// sign- or zero-extends it; reserved encodings return the full word.
module lsu_ld_fmt
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] ld_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    ld_word = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_word = {24'h0, byte_sel};
      F3_H:    ld_word = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_word = {16'h0, half_sel};
      default: ld_word = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: alignment check, store lane steering, req/ack
// handshake with timeout, and the registered load result for writeback.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lsu_en,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_stall,
  output logic [31:0] o_ld_data,
  output logic        o_ld_valid,
  output logic        o_misaligned,
  output logic        o_bus_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state, state_nxt;
  logic [7:0]  cnt;
  logic [1:0]  addr_lo;
  logic [2:0]  funct3_q;
  logic        aligned, start, ack_done, tmo;
  logic [31:0] wdata_c;
  logic [3:0]  bmask_c;
  logic [31:0] ld_word;

  // funct3[1:0] alone gives the access size; reserved codes fall into the word case
  always_comb begin
    case (i_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~i_addr[0];
      default: aligned = (i_addr[1:0] == 2'b00);
    endcase
  end

  // reset gates the combinational outputs so the core sees no stall while held in reset
  assign start        = (state == IDLE) && i_lsu_en && aligned && !i_reset;
  assign o_misaligned = (state == IDLE) && i_lsu_en && !aligned && !i_reset;
  assign ack_done     = (state == BUSY) && i_mem_ack;
  assign tmo          = (state == BUSY) && !i_mem_ack && (cnt == CNT_LAST);
  assign o_stall      = start || (state == BUSY);
  assign o_mem_req    = (state == BUSY);

  always_comb begin
    wdata_c = i_st_data;
    bmask_c = 4'b1111;
    if (i_lsu_wren) begin
      case (i_funct3[1:0])
        2'b00: begin
          wdata_c = {4{i_st_data[7:0]}};
          bmask_c = 4'b0001 << i_addr[1:0];
        end
        2'b01: begin
          wdata_c = {2{i_st_data[15:0]}};
          bmask_c = i_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (ack_done || tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // request capture at BUSY entry, timeout counter, result registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt         <= 8'h0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= 32'h0;
      o_mem_wdata <= 32'h0;
      o_mem_bmask <= 4'h0;
      o_ld_data   <= 32'h0;
      o_ld_valid  <= 1'b0;
      o_bus_err   <= 1'b0;
    end else begin
      o_ld_valid <= 1'b0;
      o_bus_err  <= 1'b0;
      if (start) begin
        cnt         <= 8'h0;
        o_mem_we    <= i_lsu_wren;
        o_mem_addr  <= {i_addr[31:2], 2'b00};
        o_mem_wdata <= wdata_c;
        o_mem_bmask <= bmask_c;
      end else if (state == BUSY) begin
        cnt <= cnt + 8'd1;
      end
      if (ack_done && !o_mem_we) begin
        o_ld_data  <= ld_word;
        o_ld_valid <= 1'b1;
      end
      if (tmo) begin
        o_ld_data <= 32'h0;
        o_bus_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (start) begin
      addr_lo  <= i_addr[1:0];
      funct3_q <= i_funct3;
    end
  end

  lsu_ld_fmt u_ld_fmt (
    .rdata   (i_mem_rdata),
    .addr_lo (addr_lo),
    .funct3  (funct3_q),
    .ld_word (ld_word)
  );

endmodule
